// File: rtl/itch_pkg.sv
// Shared constants for the ITCH stream parser: type bytes, type codes, lengths,
// register offsets and the parser state encoding.
package itch_pkg;

    localparam logic [7:0] AsciiAdd    = 8'h41;
    localparam logic [7:0] AsciiDelete = 8'h44;
    localparam logic [7:0] AsciiExec   = 8'h45;

    localparam logic [3:0] TypeNone   = 4'd0;
    localparam logic [3:0] TypeAdd    = 4'd1;
    localparam logic [3:0] TypeDelete = 4'd2;
    localparam logic [3:0] TypeExec   = 4'd3;

    localparam logic [4:0] LenAdd    = 5'd18;
    localparam logic [4:0] LenDelete = 5'd9;
    localparam logic [4:0] LenExec   = 5'd13;

    localparam logic [7:0] RegControl  = 8'h00;
    localparam logic [7:0] RegStatus   = 8'h04;
    localparam logic [7:0] RegValid    = 8'h08;
    localparam logic [7:0] RegType     = 8'h0C;
    localparam logic [7:0] RegRefLo    = 8'h10;
    localparam logic [7:0] RegRefHi    = 8'h14;
    localparam logic [7:0] RegShares   = 8'h18;
    localparam logic [7:0] RegPrice    = 8'h1C;
    localparam logic [7:0] RegSide     = 8'h20;
    localparam logic [7:0] RegMsgCount = 8'h24;
    localparam logic [7:0] RegErrCount = 8'h28;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StSkip    = 2'd2
    } itch_state_e;

    function automatic logic [3:0] type_code(input logic [7:0] b);
        case (b)
            AsciiAdd:    return TypeAdd;
            AsciiDelete: return TypeDelete;
            AsciiExec:   return TypeExec;
            default:     return TypeNone;
        endcase
    endfunction

    function automatic logic [4:0] msg_len(input logic [3:0] code);
        case (code)
            TypeAdd:    return LenAdd;
            TypeDelete: return LenDelete;
            TypeExec:   return LenExec;
            default:    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/itch_parser.sv
// Byte-wise ITCH message parser with field latches. MSG/ERROR counters are
// built only when ITCH_MSG_COUNT_EN is defined; otherwise they read 0.
module itch_parser
    import itch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic        i_clr,
    output logic [1:0]  o_state,
    output logic        o_valid,
    output logic [3:0]  o_type,
    output logic [63:0] o_ref,
    output logic [7:0]  o_side,
    output logic [31:0] o_shares,
    output logic [31:0] o_price,
    output logic [31:0] o_msg_count,
    output logic [31:0] o_err_count
);

    itch_state_e r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt, r_len, w_len_nxt, w_cnt_inc;
    logic [3:0]  r_code, w_code_nxt, w_type_code;
    logic [63:0] r_acc_ref, w_acc_ref_nxt, w_ref_m;
    logic [7:0]  r_acc_side, w_acc_side_nxt, w_side_m;
    logic [31:0] r_acc_shares, w_acc_shares_nxt, w_shares_m;
    logic [31:0] r_acc_price, w_acc_price_nxt, w_price_m;
    logic        r_valid, w_valid_nxt;
    logic [3:0]  r_type, w_type_nxt;
    logic [63:0] r_ref, w_ref_nxt;
    logic [7:0]  r_side, w_side_nxt;
    logic [31:0] r_shares, w_shares_nxt, r_price, w_price_nxt;
    logic        w_msg_evt, w_err_evt;

    assign w_type_code = type_code(i_byte);
    assign w_cnt_inc   = r_cnt + 5'd1;

    // Merge the in-flight byte into the working fields by its position (r_cnt) in the message.
    always_comb begin
        w_ref_m    = r_acc_ref;
        w_side_m   = r_acc_side;
        w_shares_m = r_acc_shares;
        w_price_m  = r_acc_price;
        if (r_cnt >= 5'd1 && r_cnt <= 5'd8) w_ref_m = {r_acc_ref[55:0], i_byte};
        if (r_code == TypeAdd) begin
            if (r_cnt == 5'd9) w_side_m = i_byte;
            if (r_cnt >= 5'd10 && r_cnt <= 5'd13) w_shares_m = {r_acc_shares[23:0], i_byte};
            if (r_cnt >= 5'd14) w_price_m = {r_acc_price[23:0], i_byte};
        end
        if (r_code == TypeExec && r_cnt >= 5'd9 && r_cnt <= 5'd12) begin
            w_shares_m = {r_acc_shares[23:0], i_byte};
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_code_nxt       = r_code;
        w_acc_ref_nxt    = r_acc_ref;
        w_acc_side_nxt   = r_acc_side;
        w_acc_shares_nxt = r_acc_shares;
        w_acc_price_nxt  = r_acc_price;
        w_valid_nxt      = r_valid & ~i_clr;
        w_type_nxt       = r_type;
        w_ref_nxt        = r_ref;
        w_side_nxt       = r_side;
        w_shares_nxt     = r_shares;
        w_price_nxt      = r_price;
        w_msg_evt        = 1'b0;
        w_err_evt        = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_valid) begin
                    if (w_type_code == TypeNone || i_last) begin
                        w_err_evt = 1'b1;
                        if (!i_last) w_state_nxt = StSkip;
                    end else begin
                        w_state_nxt      = StPayload;
                        w_cnt_nxt        = 5'd1;
                        w_len_nxt        = msg_len(w_type_code);
                        w_code_nxt       = w_type_code;
                        w_acc_ref_nxt    = '0;
                        w_acc_side_nxt   = '0;
                        w_acc_shares_nxt = '0;
                        w_acc_price_nxt  = '0;
                    end
                end
            end
            StPayload: begin
                if (i_valid) begin
                    w_cnt_nxt        = w_cnt_inc;
                    w_acc_ref_nxt    = w_ref_m;
                    w_acc_side_nxt   = w_side_m;
                    w_acc_shares_nxt = w_shares_m;
                    w_acc_price_nxt  = w_price_m;
                    if (w_cnt_inc == r_len) begin
                        // A latch overrides a same-cycle clear.
                        w_valid_nxt  = 1'b1;
                        w_type_nxt   = r_code;
                        w_ref_nxt    = w_ref_m;
                        w_side_nxt   = w_side_m;
                        w_shares_nxt = w_shares_m;
                        w_price_nxt  = w_price_m;
                        w_msg_evt    = 1'b1;
                        w_cnt_nxt    = '0;
                        if (i_last) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_err_evt   = 1'b1;
                            w_state_nxt = StSkip;
                        end
                    end else if (i_last) begin
                        w_err_evt   = 1'b1;
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            StSkip: begin
                if (i_valid && i_last) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_len        <= '0;
            r_code       <= '0;
            r_acc_ref    <= '0;
            r_acc_side   <= '0;
            r_acc_shares <= '0;
            r_acc_price  <= '0;
            r_valid      <= 1'b0;
            r_type       <= '0;
            r_ref        <= '0;
            r_side       <= '0;
            r_shares     <= '0;
            r_price      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_len        <= w_len_nxt;
            r_code       <= w_code_nxt;
            r_acc_ref    <= w_acc_ref_nxt;
            r_acc_side   <= w_acc_side_nxt;
            r_acc_shares <= w_acc_shares_nxt;
            r_acc_price  <= w_acc_price_nxt;
            r_valid      <= w_valid_nxt;
            r_type       <= w_type_nxt;
            r_ref        <= w_ref_nxt;
            r_side       <= w_side_nxt;
            r_shares     <= w_shares_nxt;
            r_price      <= w_price_nxt;
        end
    end

`ifdef ITCH_MSG_COUNT_EN
    logic [31:0] r_msg_count, r_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_msg_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_msg_evt) r_msg_count <= r_msg_count + 32'd1;
            if (w_err_evt) r_err_count <= r_err_count + 32'd1;
        end
    end

    assign o_msg_count = r_msg_count;
    assign o_err_count = r_err_count;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_msg_evt ^ w_err_evt;
    assign o_msg_count  = '0;
    assign o_err_count  = '0;
`endif

    assign o_state  = r_state;
    assign o_valid  = r_valid;
    assign o_type   = r_type;
    assign o_ref    = r_ref;
    assign o_side   = r_side;
    assign o_shares = r_shares;
    assign o_price  = r_price;

endmodule

// File: rtl/itch_axi_stream.sv
// ITCH AXI-Stream parser top: AXI-Lite register slave around itch_parser.
// Counters are included only when ITCH_MSG_COUNT_EN is defined.
module itch_axi_stream
    import itch_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 7,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready
);

    localparam int AW = C_S00_AXI_ADDR_WIDTH;

    logic                            r_awready, r_bvalid, r_arready, r_rvalid;
    logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [31:0]                     w_rdata;
    logic [AW-1:0]                   w_waddr, w_raddr;
    logic                            w_wr_hs, w_rd_hs, w_clr;
    logic [1:0]                      w_state;
    logic                            w_valid;
    logic [3:0]                      w_type;
    logic [63:0]                     w_ref;
    logic [7:0]                      w_side;
    logic [31:0]                     w_shares, w_price, w_msg_count, w_err_count;
    logic                            w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], s00_axi_wdata[C_S00_AXI_DATA_WIDTH-1:1],
                        s00_axi_wstrb[C_S00_AXI_DATA_WIDTH/8-1:1],
                        s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:8], s00_axis_tstrb};

    assign w_waddr = {s00_axi_awaddr[AW-1:2], 2'b00};
    assign w_raddr = {s00_axi_araddr[AW-1:2], 2'b00};
    assign w_wr_hs = r_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign w_rd_hs = r_arready & s00_axi_arvalid;
    assign w_clr   = w_wr_hs && (w_waddr == AW'(RegControl)) && s00_axi_wstrb[0]
                     && s00_axi_wdata[0];

    // Stream is always accepted outside reset.
    assign s00_axis_tready = s00_axi_aresetn;

    itch_parser u_parser (
        .i_clk       (s00_axi_aclk),
        .i_rst_n     (s00_axi_aresetn),
        .i_byte      (s00_axis_tdata[7:0]),
        .i_valid     (s00_axis_tvalid),
        .i_last      (s00_axis_tlast),
        .i_clr       (w_clr),
        .o_state     (w_state),
        .o_valid     (w_valid),
        .o_type      (w_type),
        .o_ref       (w_ref),
        .o_side      (w_side),
        .o_shares    (w_shares),
        .o_price     (w_price),
        .o_msg_count (w_msg_count),
        .o_err_count (w_err_count)
    );

    always_comb begin
        w_rdata = '0;
        case (w_raddr)
            AW'(RegStatus):   w_rdata = {30'd0, w_state};
            AW'(RegValid):    w_rdata = {31'd0, w_valid};
            AW'(RegType):     w_rdata = {28'd0, w_type};
            AW'(RegRefLo):    w_rdata = w_ref[31:0];
            AW'(RegRefHi):    w_rdata = w_ref[63:32];
            AW'(RegShares):   w_rdata = w_shares;
            AW'(RegPrice):    w_rdata = w_price;
            AW'(RegSide):     w_rdata = {24'd0, w_side};
            AW'(RegMsgCount): w_rdata = w_msg_count;
            AW'(RegErrCount): w_rdata = w_err_count;
            default:          w_rdata = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= ~r_awready & ~r_bvalid & s00_axi_awvalid & s00_axi_wvalid;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
            end else if (s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            r_arready <= ~r_arready & ~r_rvalid & s00_axi_arvalid;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_itch_axi_stream.sv
// Self-checking bench for itch_axi_stream: directed scenarios plus randomized
// messages checked against a message-level reference model.
module tb_itch_axi_stream;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = 4'hF;
    logic [1:0]  bresp, rresp;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = 4'hF;
    logic        tlast = 1'b0, tvalid = 1'b0, tready;

    int checks = 0;
    int errors = 0;
    logic [1:0] g_rresp, g_bresp;

    // Reference model: what the latched registers must hold.
    logic        m_valid;
    logic [3:0]  m_type;
    logic [63:0] m_ref;
    logic [7:0]  m_side;
    logic [31:0] m_shares, m_price, m_msgs, m_errs;

    always #5 clk = ~clk;

    itch_axi_stream dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tlast  (tlast),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef ITCH_MSG_COUNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    function automatic logic [3:0] code_of(input logic [7:0] ty);
        case (ty)
            8'h41:   return 4'd1;
            8'h44:   return 4'd2;
            8'h45:   return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_type = '0; m_ref = '0; m_side = '0;
        m_shares = '0; m_price = '0; m_msgs = '0; m_errs = '0;
    endtask

    task automatic model_latch(input logic [7:0] ty, input logic [63:0] rf, input logic [7:0] sd,
                               input logic [31:0] sh, input logic [31:0] pr);
        m_valid  = 1'b1;
        m_type   = code_of(ty);
        m_ref    = rf;
        m_side   = (ty == 8'h41) ? sd : 8'd0;
        m_shares = (ty == 8'h41 || ty == 8'h45) ? sh : 32'd0;
        m_price  = (ty == 8'h41) ? pr : 32'd0;
        m_msgs++;
    endtask

    task automatic build_msg(input logic [7:0] ty, input logic [63:0] rf, input logic [7:0] sd,
                             input logic [31:0] sh, input logic [31:0] pr, output byte_q_t q);
        q = {};
        q.push_back(ty);
        for (int i = 7; i >= 0; i--) q.push_back(rf[8*i +: 8]);
        if (ty == 8'h41) begin
            q.push_back(sd);
            for (int i = 3; i >= 0; i--) q.push_back(sh[8*i +: 8]);
            for (int i = 3; i >= 0; i--) q.push_back(pr[8*i +: 8]);
        end else if (ty == 8'h45) begin
            for (int i = 3; i >= 0; i--) q.push_back(sh[8*i +: 8]);
        end
    endtask

    task automatic send_beat(input logic [7:0] b, input logic last);
        tdata = {24'd0, b};
        tlast = last;
        tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t q, input int n, input logic last_on_final,
                              input logic stall);
        for (int i = 0; i < n; i++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send_beat(q[i], last_on_final && (i == n - 1));
        end
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data);
        int n;
        n = 0;
        data = 32'hDEAD_BEEF;
        araddr = addr;
        arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!arready) begin
            check("arready_timeout", {31'd0, arready}, 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rvalid) begin
            check("rvalid_timeout", {31'd0, rvalid}, 32'd1);
            return;
        end
        data = rdata;
        g_rresp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // Optionally presents a stream beat on the same edge as the write handshake.
    task automatic axi_write_ex(input logic [6:0] addr, input logic [31:0] data,
                                input logic with_byte, input logic [7:0] b);
        int n;
        n = 0;
        awaddr = addr;
        wdata = data;
        awvalid = 1'b1;
        wvalid = 1'b1;
        while (!awready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!awready) begin
            check("awready_timeout", {31'd0, awready}, 32'd1);
            awvalid = 1'b0;
            wvalid = 1'b0;
            return;
        end
        if (with_byte) begin
            tdata = {24'd0, b};
            tlast = 1'b1;
            tvalid = 1'b1;
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bvalid) begin
            check("bvalid_timeout", {31'd0, bvalid}, 32'd1);
            return;
        end
        g_bresp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data);
        axi_write_ex(addr, data, 1'b0, 8'h00);
    endtask

    task automatic check_reg(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic check_all(input string tag, input logic [1:0] exp_state);
        check_reg({tag, "_status"}, 7'h04, {30'd0, exp_state});
        check_reg({tag, "_valid"},  7'h08, {31'd0, m_valid});
        check_reg({tag, "_type"},   7'h0C, {28'd0, m_type});
        check_reg({tag, "_ref_lo"}, 7'h10, m_ref[31:0]);
        check_reg({tag, "_ref_hi"}, 7'h14, m_ref[63:32]);
        check_reg({tag, "_shares"}, 7'h18, m_shares);
        check_reg({tag, "_price"},  7'h1C, m_price);
        check_reg({tag, "_side"},   7'h20, {24'd0, m_side});
        check_reg({tag, "_msgcnt"}, 7'h24, cnt_exp(m_msgs));
        check_reg({tag, "_errcnt"}, 7'h28, cnt_exp(m_errs));
    endtask

    initial begin
        byte_q_t     q;
        logic [63:0] rf;
        logic [31:0] d;
        logic [7:0]  ty;
        logic [7:0]  sd;
        logic [31:0] sh, pr;
        int          mode, cut;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", {31'd0, tready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("tready_up", {31'd0, tready}, 32'd1);
        check_all("reset", 2'd0);
        check("rresp_okay", {30'd0, g_rresp}, 32'd0);

        // Delete message, back to back.
        build_msg(8'h44, 64'h0102030405060708, 8'h00, 32'd0, 32'd0, q);
        send_bytes(q, q.size(), 1'b1, 1'b0);
        model_latch(8'h44, 64'h0102030405060708, 8'h00, 32'd0, 32'd0);
        check_all("delete", 2'd0);

        // Add message overwrites previous latch.
        build_msg(8'h41, 64'h1122334455667788, 8'h42, 32'd100, 32'h000F4240, q);
        send_bytes(q, q.size(), 1'b1, 1'b0);
        model_latch(8'h41, 64'h1122334455667788, 8'h42, 32'd100, 32'h000F4240);
        check_all("add", 2'd0);

        axi_write(7'h00, 32'h1);
        check("bresp_okay", {30'd0, g_bresp}, 32'd0);
        m_valid = 1'b0;
        check_all("clear", 2'd0);

        // Truncated delete: no latch.
        build_msg(8'h44, 64'h0102030405060708, 8'h00, 32'd0, 32'd0, q);
        send_bytes(q, 3, 1'b1, 1'b0);
        m_errs++;
        check_all("short", 2'd0);

        // Unknown type with trailing bytes, then a good delete.
        send_beat(8'h5A, 1'b0);
        check_reg("unk_skip_status", 7'h04, 32'd2);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b1);
        m_errs++;
        check_all("unknown", 2'd0);
        send_beat(8'h5A, 1'b1);
        m_errs++;
        check_all("unknown_last", 2'd0);
        rf = {$urandom, $urandom};
        build_msg(8'h44, rf, 8'h00, 32'd0, 32'd0, q);
        send_bytes(q, q.size(), 1'b1, 1'b0);
        model_latch(8'h44, rf, 8'h00, 32'd0, 32'd0);
        check_all("after_unknown", 2'd0);

        // Exec without tlast on its final byte: latches, then skips to tlast.
        build_msg(8'h45, 64'hCAFEF00D12345678, 8'h00, 32'h00000777, 32'd0, q);
        send_bytes(q, q.size(), 1'b0, 1'b0);
        model_latch(8'h45, 64'hCAFEF00D12345678, 8'h00, 32'h00000777, 32'd0);
        m_errs++;
        check_all("no_tlast", 2'd2);
        send_beat(8'h99, 1'b0);
        send_beat(8'h98, 1'b1);
        check_reg("skip_exit", 7'h04, 32'd0);

        // Writes with no effect.
        axi_write(7'h0C, 32'hFFFF_FFFF);
        axi_write(7'h00, 32'h0000_0002);
        axi_write(7'h28, 32'h1234_5678);
        check_all("ro_write", 2'd0);
        check_reg("unmapped_2c", 7'h2C, 32'd0);
        check_reg("unmapped_7c", 7'h7C, 32'd0);

        // Final byte lands on the same edge as a CONTROL clear: latch wins.
        rf = 64'hA5A5_0000_5A5A_FFFF;
        build_msg(8'h44, rf, 8'h00, 32'd0, 32'd0, q);
        send_bytes(q, 8, 1'b0, 1'b0);
        check_reg("mid_payload_status", 7'h04, 32'd1);
        axi_write_ex(7'h00, 32'h1, 1'b1, q[8]);
        model_latch(8'h44, rf, 8'h00, 32'd0, 32'd0);
        check_all("latch_vs_clear", 2'd0);

        // Reset in the middle of an exec message.
        build_msg(8'h45, 64'h0BAD_BEEF_0000_0001, 8'h00, 32'd55, 32'd0, q);
        send_bytes(q, 5, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_tready", {31'd0, tready}, 32'd0);
        check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_all("midrst", 2'd0);
        send_bytes(q, q.size(), 1'b1, 1'b0);
        model_latch(8'h45, 64'h0BAD_BEEF_0000_0001, 8'h00, 32'd55, 32'd0);
        check_all("post_rst_exec", 2'd0);

        // Randomized messages with occasional truncation, missing tlast and stalls.
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 2))
                0:       ty = 8'h41;
                1:       ty = 8'h44;
                default: ty = 8'h45;
            endcase
            rf = {$urandom, $urandom};
            sd = 8'($urandom);
            sh = $urandom;
            pr = $urandom;
            build_msg(ty, rf, sd, sh, pr, q);
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                cut = int'($urandom_range(1, q.size() - 1));
                send_bytes(q, cut, 1'b1, 1'b1);
                m_errs++;
            end else if (mode == 1) begin
                send_bytes(q, q.size(), 1'b0, 1'b1);
                send_beat(8'h00, 1'b0);
                send_beat(8'h41, 1'b1);
                model_latch(ty, rf, sd, sh, pr);
                m_errs++;
            end else begin
                send_bytes(q, q.size(), 1'b1, 1'b1);
                model_latch(ty, rf, sd, sh, pr);
            end
            if ($urandom_range(0, 5) == 0) begin
                axi_write(7'h00, 32'h1);
                m_valid = 1'b0;
            end
            check_all($sformatf("rand%0d", k), 2'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
